// File: rtl/timer0_prescaler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer0_prescaler_pkg
//  Purpose  : OPTION register layout and reset value shared by the TMR0 block
//  Revision : 1.0  initial release
// ============================================================================
package timer0_prescaler_pkg;

    localparam int          c_OPT_T0CS     = 5;
    localparam int          c_OPT_T0SE     = 4;
    localparam int          c_OPT_PSA      = 3;
    localparam int          c_OPT_PS_MSB   = 2;
    localparam int          c_OPT_PS_LSB   = 0;
    localparam logic [5:0]  c_OPTION_RESET = 6'h3F;

endpackage : timer0_prescaler_pkg
`default_nettype wire

// File: rtl/t0cki_sync.sv
`default_nettype none
// ============================================================================
//  Module   : t0cki_sync
//  Purpose  : Two-flop synchroniser for the T0CKI pin with rise/fall detect
//  Revision : 1.0  initial release
// ============================================================================
module t0cki_sync (
    input  logic clk,
    input  logic rst,
    input  logic t0cki,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronise the pin and keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= t0cki;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_prev;
    assign fall = ~r_sync2 & r_prev;

endmodule : t0cki_sync
`default_nettype wire

// File: rtl/timer0_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : timer0_prescaler
//  Purpose  : PIC16C5x TMR0 with shared 8-bit prescaler and OPTION register
//  Revision : 1.0  initial release
// ============================================================================
module timer0_prescaler
    import timer0_prescaler_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int INHIBIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instrTick,
    input  logic                  t0cki,
    input  logic                  wdtTick,
    input  logic                  clrWdt,
    input  logic                  tmr0WriteEn,
    input  logic                  optionWriteEn,
    input  logic [DATA_WIDTH-1:0] writeDataIn,
    output logic [DATA_WIDTH-1:0] tmr0Out,
    output logic [5:0]            optionOut,
    output logic                  tmr0Ovf,
    output logic                  wdtTimeout
);

    localparam int c_INH_W = (INHIBIT_CYCLES < 1) ? 1 : $clog2(INHIBIT_CYCLES + 1);

    logic [DATA_WIDTH-1:0] r_tmr0;
    logic [DATA_WIDTH-1:0] r_prescaler;
    logic [5:0]            r_option;
    logic [c_INH_W-1:0]    r_inhibit;
    logic                  r_tmr0Ovf;
    logic                  r_wdtTimeout;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_psa;
    logic [2:0]            w_ps;
    logic [DATA_WIDTH-1:0] w_psMask;
    logic                  w_psFull;
    logic                  w_srcEvent;
    logic                  w_event;
    logic                  w_tmrInc;
    logic                  w_psInc;
    logic                  w_psClear;
    logic                  w_wdtFire;

    t0cki_sync u_t0ckiSync (
        .clk   (clk),
        .rst   (rst),
        .t0cki (t0cki),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_psa = r_option[c_OPT_PSA];
    assign w_ps  = r_option[c_OPT_PS_MSB:c_OPT_PS_LSB];

    // Low PS+1 bits of the prescaler form the active division window
    always_comb begin
        w_psMask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_psMask[i] = (i <= int'(w_ps));
        end
    end

    // Source selection, inhibit gating and prescaler routing
    always_comb begin
        w_srcEvent = r_option[c_OPT_T0CS]
                   ? (r_option[c_OPT_T0SE] ? w_fall : w_rise)
                   : instrTick;
        // A write in the same cycle or a pending inhibit swallows the event
        w_event    = w_srcEvent & ~tmr0WriteEn & (r_inhibit == '0);
        w_psFull   = ((r_prescaler & w_psMask) == w_psMask);
        w_tmrInc   = w_event & (w_psa | w_psFull);
        w_psInc    = w_psa ? wdtTick : w_event;
        w_psClear  = (tmr0WriteEn & ~w_psa)
                   | (optionWriteEn & (writeDataIn[c_OPT_PSA] != w_psa))
                   | (clrWdt & w_psa);
        // CLRWDT restarts the watchdog chain, so a coincident tick never fires
        w_wdtFire  = wdtTick & ~clrWdt & (~w_psa | w_psFull);
    end

    // TMR0 counter and its registered wrap pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr0    <= '0;
            r_tmr0Ovf <= 1'b0;
        end else begin
            r_tmr0Ovf <= 1'b0;
            if (tmr0WriteEn) begin
                r_tmr0 <= writeDataIn;
            end else if (w_tmrInc) begin
                r_tmr0    <= r_tmr0 + 1'b1;
                r_tmr0Ovf <= (r_tmr0 == '1);
            end
        end
    end

    // Shared prescaler: clear has priority over counting, wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescaler <= '0;
        end else if (w_psClear) begin
            r_prescaler <= '0;
        end else if (w_psInc) begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    // OPTION register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_option <= c_OPTION_RESET;
        end else if (optionWriteEn) begin
            r_option <= writeDataIn[5:0];
        end
    end

    // Post-write inhibit counter, paced by instruction ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inhibit <= '0;
        end else if (tmr0WriteEn) begin
            r_inhibit <= c_INH_W'(INHIBIT_CYCLES);
        end else if (instrTick && (r_inhibit != '0)) begin
            r_inhibit <= r_inhibit - 1'b1;
        end
    end

    // Registered watchdog time-out pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdtTimeout <= 1'b0;
        end else begin
            r_wdtTimeout <= w_wdtFire;
        end
    end

    assign tmr0Out    = r_tmr0;
    assign optionOut  = r_option;
    assign tmr0Ovf    = r_tmr0Ovf;
    assign wdtTimeout = r_wdtTimeout;

endmodule : timer0_prescaler
`default_nettype wire
